// File: rtl/cap_frame_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cap_frame_ctrl
//
// Frame-level sequencer sitting between the camera pixel-capture datapath and
// the RGB332 frame buffer. It arms on a start command, aligns to the falling
// edge of the camera vsync, optionally discards a number of leading frames,
// and then owns the buffer write port for exactly NPIX writes per frame.
//
// Ports
//   pclk         camera pixel clock, the only clock
//   rst          synchronous active-high reset
//   start        arm capture (only honoured in IDLE, and not together with stop)
//   stop         request halt (immediate in WAIT_VS, end-of-frame in CAPTURE)
//   mode_cont    1 = continuous, 0 = single frame; latched on an accepted start
//   skip_n       number of leading frames to discard; latched on an accepted start
//   vsync        camera vsync, high during vertical blanking
//   cap_wr_in    pixel-valid strobe from the capture datapath
//   cap_data_in  RGB332 pixel from the capture datapath
//   cap_en       enable to the capture datapath, high while capturing
//   mem_wr       buffer write enable (one cycle after the accepted strobe)
//   mem_addr     buffer write address
//   mem_data     buffer write data
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse per good (exactly NPIX pixel) frame
//   frame_err    sticky short/overlong frame flag, cleared by an accepted start
//   frame_cnt    number of good frames, wraps 255 -> 0
//   pix_cnt      writes accepted in the current frame, saturates at NPIX
//   state_dbg    current FSM state (0 IDLE, 1 WAIT_VS, 2 CAPTURE)
//
// Handshake: cap_wr_in is a single-cycle valid with no back-pressure. A strobe
// is accepted whenever the block is in CAPTURE and fewer than NPIX pixels have
// been written; any other strobe is discarded (and flagged when it overflows
// a frame). Each accepted strobe produces exactly one mem_wr cycle.
//
// NPIX-1 must be representable in AW bits, and NPIX itself must fit too since
// pix_cnt holds the saturated value NPIX.
// ---------------------------------------------------------------------------
module cap_frame_ctrl #(
    parameter int AW   = 15,
    parameter int NPIX = 19200,
    parameter int SKW  = 4
) (
    input  logic           pclk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic           mode_cont,
    input  logic [SKW-1:0] skip_n,
    input  logic           vsync,
    input  logic           cap_wr_in,
    input  logic [7:0]     cap_data_in,
    output logic           cap_en,
    output logic           mem_wr,
    output logic [AW-1:0]  mem_addr,
    output logic [7:0]     mem_data,
    output logic           busy,
    output logic           frame_done,
    output logic           frame_err,
    output logic [7:0]     frame_cnt,
    output logic [AW-1:0]  pix_cnt,
    output logic [1:0]     state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [AW-1:0] NPIX_C = AW'(NPIX);

    // Registered state
    state_t          state_q,      state_d;
    logic            vs_q,         vs_d;
    logic [SKW-1:0]  skip_left_q,  skip_left_d;
    logic            mode_q,       mode_d;
    logic            stop_pend_q,  stop_pend_d;
    logic [AW-1:0]   pix_cnt_q,    pix_cnt_d;
    logic [7:0]      frame_cnt_q,  frame_cnt_d;
    logic            frame_err_q,  frame_err_d;
    logic            frame_done_q, frame_done_d;
    logic            cap_en_q,     cap_en_d;
    logic            mem_wr_q,     mem_wr_d;
    logic [AW-1:0]   mem_addr_q,   mem_addr_d;
    logic [7:0]      mem_data_q,   mem_data_d;

    // Combinational helpers
    logic            vs_fall;
    logic            vs_rise;
    logic            wr_accept;
    logic            wr_drop;
    logic [AW-1:0]   cnt_upd;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        vs_d         = vsync;
        skip_left_d  = skip_left_q;
        mode_d       = mode_q;
        stop_pend_d  = stop_pend_q;
        pix_cnt_d    = pix_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_err_d  = frame_err_q;
        frame_done_d = 1'b0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;

        vs_fall   = vs_q & ~vsync;
        vs_rise   = ~vs_q & vsync;
        wr_accept = 1'b0;
        wr_drop   = 1'b0;
        cnt_upd   = pix_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // start together with stop is treated as "do nothing".
                if (start && !stop) begin
                    mode_d      = mode_cont;
                    skip_left_d = skip_n;
                    frame_err_d = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = ST_WAIT_VS;
                end
            end

            ST_WAIT_VS: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (vs_fall) begin
                    if (skip_left_q == '0) begin
                        state_d   = ST_CAPTURE;
                        pix_cnt_d = '0;
                    end else begin
                        skip_left_d = skip_left_q - SKW'(1);
                    end
                end
            end

            ST_CAPTURE: begin
                wr_accept = cap_wr_in && (pix_cnt_q < NPIX_C);
                wr_drop   = cap_wr_in && !(pix_cnt_q < NPIX_C);

                if (wr_accept) begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = pix_cnt_q;
                    mem_data_d = cap_data_in;
                    cnt_upd    = pix_cnt_q + AW'(1);
                end
                pix_cnt_d = cnt_upd;

                if (wr_drop) begin
                    frame_err_d = 1'b1;
                end

                // A stop here only takes effect at the end of the frame.
                if (stop) begin
                    stop_pend_d = 1'b1;
                end

                // End of frame is judged on the count including a write that
                // lands in the same cycle as the vsync rise. A stop arriving in
                // that very cycle already counts as pending.
                if (vs_rise) begin
                    if (cnt_upd == NPIX_C) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        if (mode_q && !stop_pend_d) begin
                            // Skipping only applies to the leading frames after
                            // a start; back-to-back frames are all captured.
                            skip_left_d = '0;
                            state_d     = ST_WAIT_VS;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // cap_en is registered from the next state so it is high exactly
        // while the registered state is CAPTURE.
        cap_en_d = (state_d == ST_CAPTURE);
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vs_q         <= 1'b1;
            skip_left_q  <= '0;
            mode_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
            pix_cnt_q    <= '0;
            frame_cnt_q  <= 8'd0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cap_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vs_d;
            skip_left_q  <= skip_left_d;
            mode_q       <= mode_d;
            stop_pend_q  <= stop_pend_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_err_q  <= frame_err_d;
            frame_done_q <= frame_done_d;
            cap_en_q     <= cap_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cap_en     = cap_en_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;
    assign pix_cnt    = pix_cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_cap_frame_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cap_frame_ctrl
//
// Directed bench for cap_frame_ctrl with a reduced frame size so several
// complete frames fit in a short run. A behavioural model tracks what the
// block must do from frame-level rules; a negedge compare process checks all
// outputs against it every cycle, and literal expectations pin the results of
// each scenario.
// ---------------------------------------------------------------------------
module tb_cap_frame_ctrl;

    localparam int AW   = 15;
    localparam int NPIX = 300;
    localparam int SKW  = 4;

    // Clock / reset / DUT signals
    logic           pclk = 1'b0;
    logic           rst;
    logic           start;
    logic           stop;
    logic           mode_cont;
    logic [SKW-1:0] skip_n;
    logic           vsync;
    logic           cap_wr_in;
    logic [7:0]     cap_data_in;
    logic           cap_en;
    logic           mem_wr;
    logic [AW-1:0]  mem_addr;
    logic [7:0]     mem_data;
    logic           busy;
    logic           frame_done;
    logic           frame_err;
    logic [7:0]     frame_cnt;
    logic [AW-1:0]  pix_cnt;
    logic [1:0]     state_dbg;

    always #5 pclk = ~pclk;

    cap_frame_ctrl #(.AW(AW), .NPIX(NPIX), .SKW(SKW)) dut (
        .pclk        (pclk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .mode_cont   (mode_cont),
        .skip_n      (skip_n),
        .vsync       (vsync),
        .cap_wr_in   (cap_wr_in),
        .cap_data_in (cap_data_in),
        .cap_en      (cap_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt),
        .pix_cnt     (pix_cnt),
        .state_dbg   (state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: phase is 0 idle, 1 waiting for a frame, 2 capturing.
    // -----------------------------------------------------------------------
    int         m_phase;
    bit         m_vs_prev;
    int         m_skip;
    bit         m_cont;
    bit         m_stop_req;
    int         m_count;
    int         m_frames;
    bit         m_err;
    bit         m_done;
    bit         m_wr;
    int         m_addr;
    logic [7:0] m_data;

    always @(posedge pclk) begin
        bit fall, rise, wr_now, done_now;
        if (rst) begin
            m_phase = 0; m_vs_prev = 1; m_skip = 0; m_cont = 0; m_stop_req = 0;
            m_count = 0; m_frames = 0; m_err = 0; m_done = 0; m_wr = 0;
            m_addr = 0; m_data = 8'd0;
        end else begin
            fall = m_vs_prev && !vsync;
            rise = !m_vs_prev && vsync;
            wr_now = 0;
            done_now = 0;
            if (m_phase == 0) begin
                if (start && !stop) begin
                    m_cont = mode_cont; m_skip = int'(skip_n);
                    m_err = 0; m_stop_req = 0; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (stop) m_phase = 0;
                else if (fall) begin
                    if (m_skip == 0) begin m_phase = 2; m_count = 0; end
                    else m_skip = m_skip - 1;
                end
            end else begin
                if (cap_wr_in) begin
                    if (m_count < NPIX) begin
                        wr_now = 1; m_addr = m_count; m_data = cap_data_in;
                        m_count = m_count + 1;
                    end else m_err = 1;
                end
                if (stop) m_stop_req = 1;
                if (rise) begin
                    if (m_count == NPIX) begin
                        done_now = 1;
                        m_frames = (m_frames + 1) % 256;
                        if (m_cont && !m_stop_req) begin m_skip = 0; m_phase = 1; end
                        else m_phase = 0;
                    end else begin
                        m_err = 1; m_phase = 0;
                    end
                end
            end
            m_wr = wr_now;
            m_done = done_now;
            m_vs_prev = vsync;
        end
    end

    // -----------------------------------------------------------------------
    // Compare process and write monitor (negedge, away from the active edge)
    // -----------------------------------------------------------------------
    bit cmp_en = 0;
    int wr_count;
    int done_count;
    int last_addr;
    int seen [NPIX];

    task automatic clear_counters();
        wr_count = 0; done_count = 0; last_addr = -1;
        for (int a = 0; a < NPIX; a++) seen[a] = 0;
    endtask

    always @(negedge pclk) begin
        if (cmp_en) begin
            check("mem_wr",     32'(mem_wr),     32'(m_wr));
            check("mem_addr",   32'(mem_addr),   32'(m_addr));
            check("mem_data",   32'(mem_data),   32'(m_data));
            check("busy",       32'(busy),       32'(m_phase != 0));
            check("cap_en",     32'(cap_en),     32'(m_phase == 2));
            check("frame_done", 32'(frame_done), 32'(m_done));
            check("frame_err",  32'(frame_err),  32'(m_err));
            check("frame_cnt",  32'(frame_cnt),  32'(m_frames));
            check("pix_cnt",    32'(pix_cnt),    32'(m_count));
            if (mem_wr === 1'b1) begin
                wr_count++;
                last_addr = int'(mem_addr);
                if (int'(mem_addr) < NPIX) seen[mem_addr]++;
            end
            if (frame_done === 1'b1) done_count++;
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_start(input bit cont, input int skip);
        mode_cont = cont;
        skip_n    = SKW'(skip);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // One frame: vsync falls, nwr strobes (with occasional gaps), vsync rises.
    // stop_at/start_at pulse those inputs alongside strobe number i.
    task automatic run_frame(input int nwr, input int stop_at, input int start_at,
                             input bit rise_with_last);
        vsync = 1'b0;
        tick();
        tick();
        for (int i = 0; i < nwr; i++) begin
            cap_wr_in   = 1'b1;
            cap_data_in = 8'($urandom_range(0, 255));
            stop        = (i == stop_at);
            start       = (i == start_at);
            if (rise_with_last && i == nwr - 1) vsync = 1'b1;
            tick();
            cap_wr_in = 1'b0;
            stop      = 1'b0;
            start     = 1'b0;
            if (i % 7 == 3) tick();
        end
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    // -----------------------------------------------------------------------
    // Directed scenarios
    // -----------------------------------------------------------------------
    initial begin
        int once;
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0; skip_n = '0;
        vsync = 1'b1; cap_wr_in = 1'b0; cap_data_in = 8'd0;
        clear_counters();
        tick();
        cmp_en = 1;
        tick();
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        check("reset_mem_wr", 32'(mem_wr), 32'd0);
        repeat (2) tick();

        // Single frame, last strobe coincides with vsync rise
        clear_counters();
        do_start(1'b0, 0);
        check("t1_busy_armed", 32'(busy), 32'd1);
        run_frame(NPIX, -1, -1, 1'b1);
        once = 0;
        for (int a = 0; a < NPIX; a++) if (seen[a] == 1) once++;
        check("t1_writes", 32'(wr_count), 32'(NPIX));
        check("t1_each_addr_once", 32'(once), 32'(NPIX));
        check("t1_last_addr", 32'(last_addr), 32'(NPIX - 1));
        check("t1_done_pulses", 32'(done_count), 32'd1);
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);

        // Skip two leading frames, continuous mode, five frames
        clear_counters();
        do_start(1'b1, 2);
        for (int f = 0; f < 5; f++) begin
            run_frame(NPIX, -1, -1, 1'b0);
            if (f == 1) check("t2_no_writes_while_skipping", 32'(wr_count), 32'd0);
        end
        check("t2_writes", 32'(wr_count), 32'(3 * NPIX));
        check("t2_done_pulses", 32'(done_count), 32'd3);
        check("t2_frame_cnt", 32'(frame_cnt), 32'd4);
        check("t2_busy", 32'(busy), 32'd1);
        // Stop while waiting for the next frame
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5b_stop_in_wait_busy", 32'(busy), 32'd0);
        clear_counters();
        run_frame(20, -1, -1, 1'b0);
        check("t5b_no_writes_after_stop", 32'(wr_count), 32'd0);

        // Short frame
        clear_counters();
        do_start(1'b1, 0);
        run_frame(100, -1, -1, 1'b0);
        check("t3_frame_err", 32'(frame_err), 32'd1);
        check("t3_done_pulses", 32'(done_count), 32'd0);
        check("t3_frame_cnt", 32'(frame_cnt), 32'd4);
        check("t3_busy", 32'(busy), 32'd0);
        do_start(1'b0, 0);
        check("t3_err_cleared", 32'(frame_err), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Overlong frame
        clear_counters();
        do_start(1'b0, 0);
        run_frame(NPIX + 5, -1, -1, 1'b0);
        check("t4_writes", 32'(wr_count), 32'(NPIX));
        check("t4_last_addr", 32'(last_addr), 32'(NPIX - 1));
        check("t4_frame_err", 32'(frame_err), 32'd1);
        check("t4_frame_cnt", 32'(frame_cnt), 32'd5);

        // Stop mid-capture in continuous mode; a start mid-frame is ignored
        clear_counters();
        do_start(1'b1, 0);
        run_frame(NPIX, 100, 50, 1'b0);
        check("t5_writes", 32'(wr_count), 32'(NPIX));
        check("t5_done_pulses", 32'(done_count), 32'd1);
        check("t5_frame_cnt", 32'(frame_cnt), 32'd6);
        check("t5_busy", 32'(busy), 32'd0);

        // Reset in the middle of a frame
        do_start(1'b0, 0);
        vsync = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 150; i++) begin
            cap_wr_in = 1'b1;
            cap_data_in = 8'($urandom_range(0, 255));
            tick();
        end
        check("t6_pix_cnt_before", 32'(pix_cnt), 32'd150);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cap_wr_in = 1'b0;
        check("t6_mem_wr", 32'(mem_wr), 32'd0);
        check("t6_pix_cnt", 32'(pix_cnt), 32'd0);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        vsync = 1'b1;
        tick();
        // start and stop together stay in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t6_start_stop_idle", 32'(busy), 32'd0);
        tick();
        check("t6_still_idle", 32'(busy), 32'd0);

        repeat (2) tick();
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
